// File: rtl/imem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : imem_sync
//  Description : Synchronous-read instruction memory for the SimpleARM core.
//                A one-cycle fetch port, a program-load write port and a
//                self-initialising fill sequence that runs after every reset.
//                Define IMEM_BL_PRELOAD_EN to have the fill sequence place the
//                built-in branch-and-link test image in words 0..8.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_sync #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_err,
    input  logic                  ld_we,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    // Word-index width; the range check is done on the full 30-bit index so
    // high address bits produce an error instead of aliasing onto low words.
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [AW-1:0]         init_cnt;
    logic [AW-1:0]         next_init_cnt;
    logic [DATA_WIDTH-1:0] init_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we;
    logic                  load_we;
    logic                  fetch_bad;
    logic                  load_bad;
    logic                  fetch_take;
    logic [AW-1:0]         fetch_idx;
    logic [AW-1:0]         load_idx;

`ifdef IMEM_BL_PRELOAD_EN
    // Fill source: BL/B/ADD/SUB test image in words 0..8, fill word elsewhere.
    always_comb begin
        init_data = FILL_WORD;
        case (init_cnt)
            AW'(0):  init_data = DATA_WIDTH'(32'hEB000000);
            AW'(1):  init_data = DATA_WIDTH'(32'hE2800008);
            AW'(2):  init_data = DATA_WIDTH'(32'hE0411001);
            AW'(3):  init_data = DATA_WIDTH'(32'hE2400008);
            AW'(4):  init_data = DATA_WIDTH'(32'hEA000000);
            AW'(5):  init_data = DATA_WIDTH'(32'hE2811000);
            AW'(6):  init_data = DATA_WIDTH'(32'hE2811008);
            AW'(7):  init_data = DATA_WIDTH'(32'hE2811008);
            AW'(8):  init_data = DATA_WIDTH'(32'hE2411008);
            default: init_data = FILL_WORD;
        endcase
    end
`else
    // Fill source: every word starts as the fill word.
    assign init_data = FILL_WORD;
`endif

    // Address qualification for both ports: misaligned or beyond the last word.
    always_comb begin
        fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= DEPTH_W);
        load_bad   = (ld_addr[1:0] != 2'b00) || (ld_addr[31:2] >= DEPTH_W);
        fetch_idx  = fetch_addr[AW+1:2];
        load_idx   = ld_addr[AW+1:2];
        ready      = (state == RUN);
        fetch_take = (state == RUN) && fetch_req;
        // Gating with reset keeps a held reset from repeatedly writing word 0.
        init_we    = (state == INIT) && !reset;
        load_we    = (state == RUN) && ld_we && !load_bad;
    end

    // Next-state logic: walk the init counter once over every word, then run.
    always_comb begin
        next_state    = state;
        next_init_cnt = init_cnt;
        case (state)
            INIT: begin
                if (init_cnt == LAST_IDX) begin
                    next_state    = RUN;
                    next_init_cnt = '0;
                end else begin
                    next_init_cnt = init_cnt + AW'(1);
                end
            end
            RUN: begin
                next_state = RUN;
            end
            default: begin
                next_state    = INIT;
                next_init_cnt = '0;
            end
        endcase
    end

    // State and init-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= next_state;
            init_cnt <= next_init_cnt;
        end
    end

    // Storage array: init fill and program load share the single write port;
    // the two never overlap because they are qualified by opposite states.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= init_data;
        end else if (load_we) begin
            mem[load_idx] <= ld_data;
        end
    end

    // Fetch response register; reading mem here with non-blocking semantics
    // returns the pre-write word when a load hits the same index this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_data  <= '0;
        end else begin
            fetch_valid <= fetch_take;
            if (fetch_take) begin
                fetch_err  <= fetch_bad;
                fetch_data <= fetch_bad ? '0 : mem[fetch_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_sync
//  Description : Self-checking bench for imem_sync: init timing, directed
//                vector table, randomized traffic against a word-array model,
//                and asynchronous reset during RUN and mid-INIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_sync;

    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] FILL  = 32'hE1A00000;

`ifdef IMEM_BL_PRELOAD_EN
    localparam logic [31:0] EXP_W2 = 32'hE0411001;
    localparam logic [31:0] EXP_W3 = 32'hE2400008;
    localparam logic [31:0] EXP_W4 = 32'hEA000000;
`else
    localparam logic [31:0] EXP_W2 = FILL;
    localparam logic [31:0] EXP_W3 = FILL;
    localparam logic [31:0] EXP_W4 = FILL;
`endif

    logic          clk;
    logic          reset;
    logic          ready;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_err;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [DW-1:0] ld_data;

    int tests = 0;
    int fails = 0;

    // Reference model: plain word array plus the last response values.
    logic [31:0] model [DEPTH];
    logic [31:0] last_data;
    logic        last_err;

    imem_sync #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .FILL_WORD  (FILL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] faddr;
        logic        we;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic init_model();
        logic [31:0] img [9];
        img = '{32'hEB000000, 32'hE2800008, 32'hE0411001, 32'hE2400008, 32'hEA000000,
                32'hE2811000, 32'hE2811008, 32'hE2811008, 32'hE2411008};
        for (int i = 0; i < DEPTH; i++) model[i] = FILL;
`ifdef IMEM_BL_PRELOAD_EN
        for (int i = 0; i < 9; i++) model[i] = img[i];
`else
        if (img[0] == 32'h0) model[0] = FILL;
`endif
        last_data = '0;
        last_err  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, advance the model (read before write), step the clock.
    task automatic drive(input logic req, input logic [31:0] fa, input logic we,
                         input logic [31:0] la, input logic [31:0] ld);
        fetch_req  = req;
        fetch_addr = fa;
        ld_we      = we;
        ld_addr    = la;
        ld_data    = ld;
        if (req) begin
            last_err  = addr_bad(fa);
            last_data = last_err ? 32'h0 : model[fa / 4];
        end
        if (we && !addr_bad(la)) model[la / 4] = ld;
        step();
    endtask

    // Drive one cycle and compare all response outputs against the model.
    task automatic cyc_model(input logic req, input logic [31:0] fa, input logic we,
                             input logic [31:0] la, input logic [31:0] ld);
        drive(req, fa, we, la, ld);
        check("rand_valid", {31'b0, fetch_valid}, {31'b0, req});
        check("rand_err",   {31'b0, fetch_err},   {31'b0, last_err});
        check("rand_data",  fetch_data,           last_data);
    endtask

    task automatic idle();
        fetch_req = 1'b0; fetch_addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return (32'($urandom_range(0, 15)) * 4) + 32'($urandom_range(1, 3));
        if (sel == 1) return 32'h100 + (32'($urandom_range(0, 3)) << ($urandom_range(0, 28)));
        return 32'($urandom_range(0, 15)) * 4;
    endfunction

    vec_t vecs [10];

    initial begin
        idle();
        reset = 1'b1;
        init_model();

        // Reset state
        step(); step();
        check("rst_ready", {31'b0, ready},       32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_err",   {31'b0, fetch_err},   32'h0);
        check("rst_data",  fetch_data,           32'h0);

        // Init: request and load held active must both be ignored
        reset      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        ld_we      = 1'b1;
        ld_addr    = 32'h8;
        ld_data    = 32'h11111111;
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            check($sformatf("init_ready_e%0d", e), {31'b0, ready}, (e == DEPTH) ? 32'h1 : 32'h0);
            check($sformatf("init_valid_e%0d", e), {31'b0, fetch_valid}, 32'h0);
        end
        idle();

`ifdef IMEM_BL_PRELOAD_EN
        // Preload image: three back-to-back fetches
        drive(1'b1, 32'h00, 1'b0, 32'h0, 32'h0);
        check("pre0_valid", {31'b0, fetch_valid}, 32'h1);
        check("pre0_data",  fetch_data, 32'hEB000000);
        drive(1'b1, 32'h04, 1'b0, 32'h0, 32'h0);
        check("pre1_valid", {31'b0, fetch_valid}, 32'h1);
        check("pre1_data",  fetch_data, 32'hE2800008);
        drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        check("pre2_valid", {31'b0, fetch_valid}, 32'h1);
        check("pre2_err",   {31'b0, fetch_err}, 32'h0);
        check("pre2_data",  fetch_data, 32'hE2411008);
`endif

        // Directed vector table
        vecs[0] = '{1'b0, 32'h000, 1'b1, 32'h00C, 32'hE2400008, 1'b0, 1'b0, 32'h0,        "load_0c"};
        vecs[1] = '{1'b1, 32'h00C, 1'b0, 32'h000, 32'h0,        1'b1, 1'b0, 32'hE2400008, "fetch_0c"};
        vecs[2] = '{1'b1, 32'h010, 1'b0, 32'h000, 32'h0,        1'b1, 1'b0, EXP_W4,       "fetch_10"};
        vecs[3] = '{1'b1, 32'h006, 1'b0, 32'h000, 32'h0,        1'b1, 1'b1, 32'h0,        "fetch_mis"};
        vecs[4] = '{1'b1, 32'h100, 1'b0, 32'h000, 32'h0,        1'b1, 1'b1, 32'h0,        "fetch_oor"};
        vecs[5] = '{1'b0, 32'h000, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h0,        "load_oor"};
        vecs[6] = '{1'b1, 32'h0FC, 1'b0, 32'h000, 32'h0,        1'b1, 1'b0, FILL,         "fetch_fc"};
        vecs[7] = '{1'b1, 32'h008, 1'b1, 32'h008, 32'hDEADBEEF, 1'b1, 1'b0, EXP_W2,       "rbw_old"};
        vecs[8] = '{1'b1, 32'h008, 1'b0, 32'h000, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, "rbw_new"};
        vecs[9] = '{1'b1, 32'h4000_0000, 1'b0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h0,        "fetch_hi"};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].req, vecs[i].faddr, vecs[i].we, vecs[i].laddr, vecs[i].ldata);
            check({vecs[i].name, "_valid"}, {31'b0, fetch_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check({vecs[i].name, "_err"},  {31'b0, fetch_err}, {31'b0, vecs[i].exp_err});
                check({vecs[i].name, "_data"}, fetch_data, vecs[i].exp_data);
            end
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc_model($urandom_range(0, 3) != 0, rand_addr(),
                      $urandom_range(0, 2) == 0, rand_addr(), $urandom());
        end
        idle();

        // Asynchronous reset with a response on the outputs
        drive(1'b1, 32'h00C, 1'b1, 32'h00C, 32'hCAFEF00D);
        check("pre_rst_valid", {31'b0, fetch_valid}, 32'h1);
        idle();
        #2 reset = 1'b1;
        #1;
        check("arst_ready", {31'b0, ready},       32'h0);
        check("arst_valid", {31'b0, fetch_valid}, 32'h0);
        check("arst_data",  fetch_data,           32'h0);
        step();
        reset = 1'b0;

        // Reset again at init cycle 30
        for (int e = 0; e < 30; e++) step();
        check("mid_init_ready", {31'b0, ready}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, ready},       32'h0);
        check("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        reset = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            check($sformatf("reinit_ready_e%0d", e), {31'b0, ready}, (e == DEPTH) ? 32'h1 : 32'h0);
        end

        // Loaded words are back to their init values
        init_model();
        drive(1'b1, 32'h008, 1'b0, 32'h0, 32'h0);
        check("reinit_08", fetch_data, EXP_W2);
        drive(1'b1, 32'h00C, 1'b0, 32'h0, 32'h0);
        check("reinit_0c", fetch_data, EXP_W3);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("hold_valid", {31'b0, fetch_valid}, 32'h0);
        check("hold_data",  fetch_data, EXP_W3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous-read instruction memory for the SimpleARM core and its benches. It replaces the combinational, hard-coded program ROM with a clocked fetch port, a program-load write port and a self-initialising fill sequence after reset. An optional built-in branch-and-link test image is also provided. It sits between the fetch stage (PC → instruction) and the testbench or boot loader that writes programs.

## Interface
- DATA_WIDTH, 32, instruction word width in bits
- DEPTH, 64, number of words; power of two, ≥ 16
- FILL_WORD, 32'h00000000, value written to every non-preloaded word during init
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high
- ready  out  1  memory initialised and accepting fetch/load
- fetch_req  in  1  fetch request, sampled on clk when ready=1
- fetch_addr  in  32  byte address; word index = fetch_addr[31:2]
- fetch_valid  out  1  one-cycle pulse, response for the request of the previous cycle
- fetch_data  out  DATA_WIDTH  instruction word
- fetch_err  out  1  qualifies fetch_valid: address misaligned or out of range
- ld_we  in  1  program-load write enable
- ld_addr  in  32  byte address of the load
- ld_data  in  DATA_WIDTH  word to write

## Operation
- States: INIT, RUN.
- Reset, asynchronous: state=INIT, init counter=0. Outputs ready=0, fetch_valid=0, fetch_err=0, fetch_data=0.
- INIT writes one word per cycle at counter index, then increments the counter. The word written is FILL_WORD, or the preload image (see Configuration). After index DEPTH-1 is written, the state goes to RUN.
- In INIT, fetch_req and ld_we are ignored. No fetch_valid is produced.
- RUN: ready=1. The block stays in RUN until reset.
- Fetch in RUN, fetch_req=1:
  - The address is checked.
  - err = (fetch_addr[1:0]≠0) or (fetch_addr[31:2] ≥ DEPTH).
  - On the next cycle: fetch_valid=1, fetch_err=err, fetch_data = err ? 0 : mem[index].
- fetch_req=0 gives fetch_valid=0 on the next cycle. fetch_data and fetch_err then hold their last values.
- Load in RUN, ld_we=1, with a valid, aligned, in-range ld_addr: mem[ld_addr[31:2]] ← ld_data.
  - A misaligned or out-of-range load is silently dropped.
- Fetch and load to the same word in the same cycle: the fetch returns the old contents (read-before-write). The new contents are visible from the next request onward.
- Index arithmetic uses log2(DEPTH) bits after the range check. There is no wrap-around; high address bits cause an error, not aliasing.

## Timing
- Fetch latency is exactly 1 cycle, request edge → valid edge. Full throughput: one request per cycle, back-to-back.
- Init duration is DEPTH cycles after reset deassertion. ready rises on the clk edge that completes word DEPTH-1. With DEPTH=64, the first edge after release writes word 0, and ready=1 after the 64th edge.
- A load write takes effect at the clk edge where ld_we is sampled.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs clear immediately (asynchronously).
  - The counter returns to 0.
  - Init restarts in full on release.
  - Any in-flight fetch response is discarded.
- There is no backpressure. The consumer must accept fetch_valid on the cycle it is high.

## Configuration
- IMEM_BL_PRELOAD_EN defined: INIT writes this image to words 0–8, and FILL_WORD to the rest:
  - EB000000, E2800008, E0411001, E2400008, EA000000, E2811000, E2811008, E2811008, E2411008.
  - This is the BL/B/ADD/SUB test image.
- Not defined: every word is initialised to FILL_WORD, and programs must be loaded through the ld_* port after ready.
- Port list and timing are identical either way.

## Test plan
- Reset, then release, DEPTH=64: ready=0 for 63 edges, then ready=1 after the 64th edge. No fetch_valid during INIT, even with fetch_req held at 1.
- With IMEM_BL_PRELOAD_EN: fetch addresses 0x00, 0x04, 0x20 on consecutive cycles → fetch_valid for 3 consecutive cycles, with data EB000000, E2800008, E2411008 and fetch_err=0.
- Without the macro: load 0x0C ← E2400008, then fetch 0x0C → data E2400008. Fetch 0x10 → data FILL_WORD.
- Error cases:
  - Fetch 0x06 → fetch_valid=1, fetch_err=1, data 0.
  - Fetch 0x100 (index 64) → fetch_err=1.
  - Load to 0x100, then fetch 0xFC → unchanged contents.
- Same-cycle load 0x08 ← DEADBEEF and fetch 0x08 → old word returned. Fetch 0x08 on the next cycle → DEADBEEF.
- Reset asserted at init cycle 30: ready and fetch_valid go to 0 immediately. After release, ready needs a full 64 cycles again, and any loaded word reads back as its init value.
